// File: rtl/spi_pkg.sv
// Shared SPI definitions for the DE0-CV lab link: FSM state encoding and the
// default frame geometry that the master and the slave receiver both use.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } spi_state_e;

  localparam int SPI_DATA_W  = 16;
  localparam int SPI_CLK_DIV = 10;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter for the SPI clock: while enabled it toggles sclk every
// CLK_DIV/2 cycles and flags the cycle before each registered edge.
module spi_sclk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = $clog2(HALF) + 1;

  if ((CLK_DIV % 2) != 0 || CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_sclk_gen: CLK_DIV must be even and >= 4");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick      = enable && (cnt_q == CNT_W'(HALF - 1));
  assign rise_tick = tick && !sclk_q;
  assign fall_tick = tick && sclk_q;
  assign sclk      = sclk_q;

  // NOTE: every _d gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (enable) begin
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      sclk_d = sclk_q ^ tick;
    end
  end

  // NOTE: flops update with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one DATA_W-bit word per ssn-low frame, MSB first.
// Define SPI_MISO_CAPTURE_EN to also capture miso into rx_data.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int GAP_CYC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              ssn,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data
);

  localparam int HALF     = CLK_DIV / 2;
  localparam int BIT_W    = $clog2(DATA_W) + 1;
  localparam int WAIT_MAX = (HALF > GAP_CYC) ? HALF : GAP_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

  if (DATA_W < 2) begin : g_bad_data_w
    $error("spi_master_tx: DATA_W must be >= 2");
  end
  if (GAP_CYC < 1) begin : g_bad_gap_cyc
    $error("spi_master_tx: GAP_CYC must be >= 1");
  end

  spi_state_e        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic              mosi_q, mosi_d;
  logic              ssn_q, ssn_d;
  logic              done_q, done_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              sclk_en, rise_tick, fall_tick;

  // The edge generator runs only while sclk may toggle; TRAIL and GAP use wait_cnt.
  assign sclk_en = (state_q == LEAD) || (state_q == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (sclk_en),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .sclk     (sclk)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    shreg_d    = shreg_q;
    mosi_d     = mosi_q;
    ssn_d      = ssn_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d   = LEAD;
          bit_cnt_d = '0;
          shreg_d   = tx_data[DATA_W-2:0];
          mosi_d    = tx_data[DATA_W-1];
          ssn_d     = 1'b0;
        end
      end
      LEAD: begin
        if (rise_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (fall_tick) begin
          if (bit_cnt_q == BIT_W'(DATA_W)) begin
            state_d    = TRAIL;
            wait_cnt_d = '0;
          end else begin
            mosi_d  = shreg_q[DATA_W-2];
            shreg_d = shreg_q << 1;
          end
        end
      end
      TRAIL: begin
        if (wait_cnt_q == WAIT_W'(HALF - 1)) begin
          state_d    = GAP;
          wait_cnt_d = '0;
          ssn_d      = 1'b1;
          mosi_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (wait_cnt_q == WAIT_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_ready_d = (state_d == IDLE);
    busy_d     = !tx_ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      shreg_q    <= '0;
      mosi_q     <= 1'b0;
      ssn_q      <= 1'b1;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      shreg_q    <= shreg_d;
      mosi_q     <= mosi_d;
      ssn_q      <= ssn_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign mosi     = mosi_q;
  assign ssn      = ssn_q;
  assign done     = done_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

`ifdef SPI_MISO_CAPTURE_EN
  logic              miso_s1_q, miso_s1_d;
  logic              miso_s2_q, miso_s2_d;
  logic [2:0]        rise_pipe_q, rise_pipe_d;
  logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  // Sample two cycles after sclk rises: by then miso_s2 holds the pin value of the rise cycle.
  always_comb begin
    miso_s1_d   = miso;
    miso_s2_d   = miso_s1_q;
    rise_pipe_d = {rise_pipe_q[1:0], rise_tick};
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    if (rise_pipe_q[2]) begin
      rx_shreg_d = {rx_shreg_q[DATA_W-2:0], miso_s2_q};
    end
    if (done_d) begin
      rx_data_d = rx_shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      rise_pipe_q <= '0;
      rx_shreg_q  <= '0;
      rx_data_q   <= '0;
    end else begin
      miso_s1_q   <= miso_s1_d;
      miso_s2_q   <= miso_s2_d;
      rise_pipe_q <= rise_pipe_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: stimulus queues expected frames, a
// monitor decodes mosi/ssn/done and checks each completed frame.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int DW          = SPI_DATA_W;
  localparam int GAP_CYC_TB  = 10;
  localparam int SSN_LOW_CYC = 165;   // t0+1 .. t0+165 at the default geometry

`ifdef SPI_MISO_CAPTURE_EN
  localparam logic [15:0] EXP_RX = 16'h5A5A;
`else
  localparam logic [15:0] EXP_RX = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready, busy, done, sclk, mosi, ssn, miso;
  logic [15:0] rx_data;

  logic        f_tx_valid = 1'b0;
  logic [15:0] f_tx_data = '0;
  logic        f_tx_ready, f_busy, f_done, f_sclk, f_mosi, f_ssn;
  logic [15:0] f_rx_data;

  always #5 clk = ~clk;

  spi_master_tx u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
    .ssn(ssn), .miso(miso), .rx_data(rx_data)
  );

  spi_master_tx #(.DATA_W(16), .CLK_DIV(4), .GAP_CYC(2)) u_fast (
    .clk(clk), .reset(reset), .tx_data(f_tx_data), .tx_valid(f_tx_valid),
    .tx_ready(f_tx_ready), .busy(f_busy), .done(f_done), .sclk(f_sclk),
    .mosi(f_mosi), .ssn(f_ssn), .miso(1'b0), .rx_data(f_rx_data)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] rx;
  } exp_t;
  exp_t sb_q[$];

  // Downstream slave model: shifts mosi in on sclk rises, drives 16'h5A5A on miso.
  logic [15:0] slave_rx = '0, slave_tx = '0, data_debug = '0;
  logic        ps_sclk = 1'b0, ps_ssn = 1'b1;
  assign miso = slave_tx[15];

  always @(posedge clk) begin
    ps_sclk <= sclk;
    ps_ssn  <= ssn;
    if (ps_ssn && !ssn) slave_tx <= 16'h5A5A;
    else if (ps_sclk && !sclk && !ssn) slave_tx <= slave_tx << 1;
    if (!ps_sclk && sclk && !ssn) slave_rx <= {slave_rx[14:0], mosi};
    if (!ps_ssn && ssn) data_debug <= slave_rx;
  end

  // Monitor: decodes each ssn-low frame and scores it when ssn rises.
  int          cyc = 0, rises = 0, fall_cyc = 0;
  logic [15:0] got = '0;
  logic        in_frame = 1'b0, m_ssn = 1'b1, m_sclk = 1'b0, rs;
  exp_t        e;

  always @(posedge clk) begin
    rs = reset;
    #1;
    cyc++;
    if (rs) begin
      in_frame = 1'b0;
    end else begin
      if (m_ssn && !ssn) begin
        in_frame = 1'b1;
        rises    = 0;
        got      = '0;
        fall_cyc = cyc;
      end
      if (in_frame && !m_sclk && sclk) begin
        got = {got[14:0], mosi};
        rises++;
      end
      if (in_frame && !m_ssn && ssn) begin
        in_frame = 1'b0;
        check("done_at_ssn_rise", int'(done), 1);
        if (sb_q.size() == 0) begin
          check("frame_expected", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check("mosi_word", int'(got), int'(e.data));
          check("rise_count", rises, DW);
          check("ssn_low_cycles", cyc - fall_cyc, SSN_LOW_CYC);
          check("rx_data", int'(rx_data), int'(e.rx));
        end
      end else if (done) begin
        check("stray_done", int'(done), 0);
      end
    end
    m_ssn  = ssn;
    m_sclk = sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!tx_ready && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(tx_ready), 1);
  endtask

  task automatic send(input logic [15:0] w, input bit expect_done);
    wait_ready("ready_before_send");
    tx_data  = w;
    tx_valid = 1'b1;
    if (expect_done) sb_q.push_back('{data: w, rx: EXP_RX});
    tick();
    tx_valid = 1'b0;
    tx_data  = 16'(~w);
    check("lead_ssn", int'(ssn), 0);
    check("lead_mosi", int'(mosi), int'(w[15]));
    check("lead_busy", int'(busy), 1);
    check("lead_tx_ready", int'(tx_ready), 0);
  endtask

  int          n, r, hi, rdy, act, dcnt, last, badp;
  logic        pv;
  logic [15:0] fw;

  initial begin
    // tx_valid during reset must be ignored.
    tx_valid = 1'b1;
    tx_data  = 16'hDEAD;
    repeat (3) tick();
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_ssn", int'(ssn), 1);
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rx_data", int'(rx_data), 0);
    reset    = 1'b0;
    tx_valid = 1'b0;
    tick();
    check("ready_after_reset", int'(tx_ready), 1);
    check("no_frame_from_reset_valid", int'(ssn), 1);

    send(16'hA5C3, 1'b1);
    wait_ready("frame_a5c3_end");

    // Back-to-back: tx_valid held high across two frames.
    tx_data  = 16'h0001;
    tx_valid = 1'b1;
    sb_q.push_back('{data: 16'h0001, rx: EXP_RX});
    sb_q.push_back('{data: 16'hFFFF, rx: EXP_RX});
    tick();
    check("b2b_first_busy", int'(busy), 1);
    tx_data = 16'hFFFF;
    n = 0;
    while (!ssn && n < 300) begin
      tick();
      n++;
    end
    check("b2b_first_end", int'(ssn), 1);
    hi = 0; rdy = 0; act = 0; n = 0;
    while (ssn && n < 100) begin
      hi++;
      if (tx_ready) rdy++;
      if (sclk) act++;
      tick();
      n++;
    end
    tx_valid = 1'b0;
    // GAP_CYC cycles before tx_ready, plus the single accept cycle itself.
    check("b2b_ssn_high", hi, GAP_CYC_TB + 1);
    check("b2b_ready_cycles", rdy, 1);
    check("b2b_sclk_idle", act, 0);
    check("b2b_second_started", int'(ssn), 0);
    wait_ready("b2b_second_end");

    // Reset during bit 7 discards the word.
    send(16'h3C3C, 1'b0);
    r = 0; n = 0; pv = sclk;
    while (r < 8 && n < 300) begin
      tick();
      if (sclk && !pv) r++;
      pv = sclk;
      n++;
    end
    check("abort_reached_bit7", r, 8);
    reset = 1'b1;
    tick();
    check("abort_ssn", int'(ssn), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_mosi", int'(mosi), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b0;
    dcnt = 0;
    repeat (20) begin
      tick();
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    send(16'h1234, 1'b1);
    wait_ready("frame_1234_end");

    send(16'hBEEF, 1'b1);
    wait_ready("frame_beef_end");
    check("slave_data_debug", int'(data_debug), 16'hBEEF);

    // CLK_DIV=4 instance: period 4 cycles, 16 rises.
    n = 0;
    while (!f_tx_ready && n < 100) begin
      tick();
      n++;
    end
    check("fast_ready", int'(f_tx_ready), 1);
    f_tx_data  = 16'hC0DE;
    f_tx_valid = 1'b1;
    tick();
    f_tx_valid = 1'b0;
    r = 0; n = 0; last = -1; badp = 0; fw = '0; pv = f_sclk;
    while (!f_done && n < 200) begin
      if (f_sclk && !pv) begin
        fw = {fw[14:0], f_mosi};
        if (last >= 0 && (n - last) != 4) badp++;
        last = n;
        r++;
      end
      pv = f_sclk;
      tick();
      n++;
    end
    check("fast_done", int'(f_done), 1);
    check("fast_rises", r, 16);
    check("fast_period_errors", badp, 0);
    check("fast_word", int'(fw), 16'hC0DE);

    repeat (5) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
